// File: rtl/activation_lut_writer.sv
// activation_lut_writer: streams 16 samples into a shadow bank, then swaps it atomically
// into the active bank that drives the registered base/next_data lookup.
`default_nettype none

module activation_lut_writer #(
  parameter int ENTRIES = 16,
  parameter int DATA_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_start,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic                     busy,
  output logic                     load_done,
  output logic                     table_valid,
  input  logic [3:0]               address,
  output logic signed [DATA_W-1:0] base,
  output logic signed [DATA_W-1:0] next_data
);

  localparam int ADDR_W = 4;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ENTRIES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [ADDR_W-1:0]        wcnt;
  logic                     wcnt_last;
  logic                     wr_fire;
  logic                     restart;
  logic                     swap;
  logic [ADDR_W-1:0]        next_addr;
  logic signed [DATA_W-1:0] shadow [ENTRIES];
  logic signed [DATA_W-1:0] active [ENTRIES];

  assign wcnt_last = (wcnt == LAST_ADDR);
  // The upper neighbour saturates at the last entry instead of wrapping to 0.
  assign next_addr = (address == LAST_ADDR) ? LAST_ADDR : address + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    wr_ready   = 1'b0;
    busy       = 1'b0;
    wr_fire    = 1'b0;
    restart    = 1'b0;
    swap       = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) begin
          state_next = LOAD;
          restart    = 1'b1;
        end
      end
      LOAD: begin
        wr_ready = 1'b1;
        busy     = 1'b1;
        // A restart wins over a sample presented in the same cycle.
        if (load_start) begin
          restart = 1'b1;
        end else if (wr_valid) begin
          wr_fire = 1'b1;
          if (wcnt_last) begin
            state_next = COMMIT;
          end
        end
      end
      COMMIT: begin
        busy       = 1'b1;
        swap       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt <= '0;
    end else if (restart) begin
      wcnt <= '0;
    end else if (wr_fire) begin
      wcnt <= wcnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        shadow[i] <= '0;
      end
    end else if (wr_fire) begin
      shadow[wcnt] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        active[i] <= '0;
      end
    end else if (swap) begin
      for (int i = 0; i < ENTRIES; i++) begin
        active[i] <= shadow[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      table_valid <= 1'b0;
      load_done   <= 1'b0;
    end else begin
      load_done <= swap;
      if (swap) begin
        table_valid <= 1'b1;
      end
    end
  end

  // Lookup samples the bank before the swap edge takes effect, so a table is never mixed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base      <= '0;
      next_data <= '0;
    end else begin
      base      <= active[address];
      next_data <= active[next_addr];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_activation_lut_writer.sv
// Bench for activation_lut_writer: vector table plus hand sequences, lookups checked via a queue.
`default_nettype none

module tb_activation_lut_writer;

  typedef logic signed [7:0] tab_t [16];

  typedef struct {
    logic [3:0]        addr;
    logic signed [7:0] exp_base;
    logic signed [7:0] exp_next;
  } vec_t;

  typedef struct {
    string             name;
    logic signed [7:0] exp_base;
    logic signed [7:0] exp_next;
  } sb_t;

  logic              clk;
  logic              rst;
  logic              load_start;
  logic signed [7:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic              busy;
  logic              load_done;
  logic              table_valid;
  logic [3:0]        address;
  logic signed [7:0] base;
  logic signed [7:0] next_data;

  int   tests = 0;
  int   fails = 0;
  int   busy_cnt = 0;
  tab_t exp_tab;
  tab_t tab_a;
  tab_t tab_b;
  tab_t tab_c;
  vec_t vecs [6];
  sb_t  sbq [$];

  activation_lut_writer #(.ENTRIES(16), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .busy       (busy),
    .load_done  (load_done),
    .table_valid(table_valid),
    .address    (address),
    .base       (base),
    .next_data  (next_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (busy) busy_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive an address, queue its expectation, compare once the registered result appears.
  task automatic lookup(input string name, input logic [3:0] a,
                        input logic signed [7:0] eb, input logic signed [7:0] en);
    sb_t e;
    sb_t got;
    e.name = name;
    e.exp_base = eb;
    e.exp_next = en;
    address = a;
    sbq.push_back(e);
    @(negedge clk);
    got = sbq.pop_front();
    chk({got.name, "_base"}, int'(base), int'(got.exp_base));
    chk({got.name, "_next"}, int'(next_data), int'(got.exp_next));
  endtask

  task automatic model_lookup(input string name, input logic [3:0] a);
    int hi;
    hi = (a == 4'd15) ? 15 : int'(a) + 1;
    lookup(name, a, exp_tab[a], exp_tab[hi]);
  endtask

  task automatic send_samples(input tab_t vals, input int n, input bit gaps);
    for (int k = 0; k < n; k++) begin
      int guard = 0;
      while (!wr_ready && guard < 64) begin
        @(negedge clk);
        guard++;
      end
      if (!wr_ready) begin
        tests++;
        fails++;
        $display("FAIL wr_ready_timeout: got 0 expected 1");
      end
      wr_valid = 1'b1;
      wr_data  = vals[k];
      @(negedge clk);
      wr_valid = 1'b0;
      if (gaps && k < n - 1) @(negedge clk);
    end
  endtask

  task automatic start_load();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // Called at the negedge right after the last sample is accepted (COMMIT cycle).
  task automatic finish_commit(input string name, input tab_t vals);
    chk({name, "_commit_busy"}, int'(busy), 1);
    chk({name, "_commit_ready"}, int'(wr_ready), 0);
    chk({name, "_commit_done_early"}, int'(load_done), 0);
    @(negedge clk);
    chk({name, "_load_done"}, int'(load_done), 1);
    chk({name, "_table_valid"}, int'(table_valid), 1);
    chk({name, "_busy_off"}, int'(busy), 0);
    exp_tab = vals;
    @(negedge clk);
    chk({name, "_load_done_pulse"}, int'(load_done), 0);
  endtask

  initial begin
    rst = 1'b0;
    load_start = 1'b0;
    wr_valid = 1'b0;
    wr_data = '0;
    address = '0;
    for (int k = 0; k < 16; k++) begin
      exp_tab[k] = '0;
      tab_a[k]   = 8'(k * 8 - 64);
      tab_b[k]   = 8'sh7F;
      tab_c[k]   = 8'(100 - k * 13);
    end
    vecs[0] = '{4'd3,  -8'sd40, -8'sd32};
    vecs[1] = '{4'd15,  8'sd56,  8'sd56};
    vecs[2] = '{4'd0,  -8'sd64, -8'sd56};
    vecs[3] = '{4'd7,  -8'sd8,   8'sd0};
    vecs[4] = '{4'd14,  8'sd48,  8'sd56};
    vecs[5] = '{4'd8,   8'sd0,   8'sd8};

    repeat (3) @(negedge clk);
    chk("rst_base", int'(base), 0);
    chk("rst_next", int'(next_data), 0);
    chk("rst_ready", int'(wr_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(load_done), 0);
    chk("rst_valid", int'(table_valid), 0);
    rst = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 16; a++) model_lookup("reset_lookup", 4'(a));
    chk("idle_valid", int'(table_valid), 0);
    chk("idle_ready", int'(wr_ready), 0);

    // Back-to-back load of -64..56
    busy_cnt = 0;
    start_load();
    send_samples(tab_a, 16, 1'b0);
    finish_commit("loadA", tab_a);
    for (int i = 0; i < 6; i++) lookup("vecA", vecs[i].addr, vecs[i].exp_base, vecs[i].exp_next);
    chk("loadA_busy_cycles", busy_cnt, 17);

    // Same table with wr_valid toggling
    busy_cnt = 0;
    start_load();
    send_samples(tab_a, 16, 1'b1);
    finish_commit("gapA", tab_a);
    for (int a = 0; a < 16; a++) model_lookup("gapA_lookup", 4'(a));
    chk("gapA_busy_cycles", busy_cnt, 32);

    // Abort after 5 samples of B, restart with data presented, then full B
    start_load();
    send_samples(tab_b, 5, 1'b0);
    model_lookup("abort_old_a3", 4'd3);
    model_lookup("abort_old_a15", 4'd15);
    chk("abort_busy", int'(busy), 1);
    load_start = 1'b1;
    wr_valid   = 1'b1;
    wr_data    = 8'sh11;
    @(negedge clk);
    load_start = 1'b0;
    wr_valid   = 1'b0;
    model_lookup("restart_old_a0", 4'd0);
    send_samples(tab_b, 16, 1'b0);
    finish_commit("loadB", tab_b);
    for (int a = 0; a < 16; a++) lookup("loadB_lookup", 4'(a), 8'sh7F, 8'sh7F);

    // Writes while idle must be ignored
    wr_valid = 1'b1;
    wr_data  = 8'sh55;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_wr_ready", int'(wr_ready), 0);
      chk("idle_wr_done", int'(load_done), 0);
    end
    wr_valid = 1'b0;
    model_lookup("idle_wr_a0", 4'd0);
    model_lookup("idle_wr_a9", 4'd9);

    // Asynchronous reset in the middle of a load
    address = 4'd5;
    start_load();
    send_samples(tab_c, 10, 1'b0);
    chk("pre_rst_base", int'(base), 127);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_base", int'(base), 0);
    chk("async_rst_next", int'(next_data), 0);
    chk("async_rst_valid", int'(table_valid), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_ready", int'(wr_ready), 0);
    for (int k = 0; k < 16; k++) exp_tab[k] = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    model_lookup("post_rst_a5", 4'd5);
    model_lookup("post_rst_a15", 4'd15);
    start_load();
    send_samples(tab_c, 16, 1'b0);
    finish_commit("loadC", tab_c);
    for (int a = 0; a < 16; a++) model_lookup("loadC_lookup", 4'(a));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
